// File: rtl/graph_pkg.sv
// Shared SSSP graph-pipeline types and small lane helpers.
// Pure declarations: no logic, no latency, no flow control.
// Used by blocks that consume the four per-lane edge-pipeline outputs.
package graph_pkg;

    localparam int LANES    = 4;
    localparam int UPDATE_W = 64;

    typedef logic [UPDATE_W-1:0] update_t;

    // Number of set bits in a lane-valid vector, 0..4.
    function automatic logic [2:0] lane_popcount(input logic [3:0] v);
        logic [2:0] n;
        n = 3'd0;
        for (int k = 0; k < 4; k++) begin
            n = n + {2'b00, v[k]};
        end
        return n;
    endfunction

    // MSB-first thermometer: the downstream line buffer accepts only these five codes.
    function automatic logic [3:0] count_to_thermo(input logic [2:0] n);
        logic [3:0] t;
        case (n)
            3'd0:    t = 4'b0000;
            3'd1:    t = 4'b1000;
            3'd2:    t = 4'b1100;
            3'd3:    t = 4'b1110;
            3'd4:    t = 4'b1111;
            default: t = 4'b0000;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/update_compactor.sv
// Left-packs the valid lanes of four pipeline updates, preserving lane order.
// Latency: 1 cycle, registered outputs; end-of-stream flag delayed alongside.
// No backpressure: a new group is accepted every cycle.
module update_compactor
    import graph_pkg::lane_popcount;
    import graph_pkg::count_to_thermo;
#(
    parameter int DATA_W = 64,
    parameter int LANES  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              last_input_in,
    input  logic [3:0]        word_in_valid,
    input  logic [DATA_W-1:0] word_in [4],
    output logic              last_input_out,
    output logic [3:0]        word_out_valid,
    output logic [DATA_W-1:0] word_out [4]
);

    logic [DATA_W-1:0] next_word [4];
    logic [3:0]        next_valid;
    logic [2:0]        slot;

    // Invalid lanes are never selected, so X on their data cannot reach the outputs.
    always_comb begin
        for (int j = 0; j < 4; j++) begin
            next_word[j] = '0;
        end
        slot = 3'd0;
        for (int k = 0; k < 4; k++) begin
            if (word_in_valid[k]) begin
                next_word[slot[1:0]] = word_in[k];
                slot = slot + 3'd1;
            end
        end
        next_valid = count_to_thermo(lane_popcount(word_in_valid));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_input_out <= 1'b0;
            word_out_valid <= 4'b0000;
            for (int j = 0; j < 4; j++) begin
                word_out[j] <= '0;
            end
        end else begin
            last_input_out <= last_input_in;
            word_out_valid <= next_valid;
            for (int j = 0; j < 4; j++) begin
                word_out[j] <= next_word[j];
            end
        end
    end

endmodule

// File: tb/tb_update_compactor.sv
// Self-checking bench for update_compactor against a queue-based packing model.
module tb_update_compactor;

    logic        clk = 1'b0;
    logic        rst;
    logic        last_input_in;
    logic [3:0]  word_in_valid;
    logic [63:0] word_in [4];
    logic        last_input_out;
    logic [3:0]  word_out_valid;
    logic [63:0] word_out [4];

    int vectors     = 0;
    int miscompares = 0;

    logic [63:0] exp_word [4];
    logic [3:0]  exp_valid;
    logic        exp_last;

    update_compactor dut (
        .clk            (clk),
        .rst            (rst),
        .last_input_in  (last_input_in),
        .word_in_valid  (word_in_valid),
        .word_in        (word_in),
        .last_input_out (last_input_out),
        .word_out_valid (word_out_valid),
        .word_out       (word_out)
    );

    always #5 clk = ~clk;

    // Reference: gather valid lanes in order, count them, pad with zeros.
    function automatic void model(input logic r);
        logic [63:0] q [$];
        int n;
        for (int k = 0; k < 4; k++) begin
            if (word_in_valid[k]) q.push_back(word_in[k]);
        end
        n = q.size();
        exp_valid = 4'((15 << (4 - n)) & 15);
        for (int j = 0; j < 4; j++) exp_word[j] = (j < n) ? q[j] : 64'd0;
        exp_last = last_input_in;
        if (r) begin
            exp_valid = 4'b0000;
            exp_last  = 1'b0;
            for (int j = 0; j < 4; j++) exp_word[j] = 64'd0;
        end
    endfunction

    task automatic drive(input logic r, input logic l, input logic [3:0] v,
                         input logic [63:0] d0, input logic [63:0] d1,
                         input logic [63:0] d2, input logic [63:0] d3);
        rst           = r;
        last_input_in = l;
        word_in_valid = v;
        word_in[0] = d0; word_in[1] = d1; word_in[2] = d2; word_in[3] = d3;
        model(r);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        drive(1'b1, 1'b1, 4'b1111, 64'h1, 64'h2, 64'h3, 64'h4);
        if (word_out_valid !== 4'b0000) begin
            miscompares++; $display("FAIL reset_valid got %b want 0000", word_out_valid);
        end
        vectors++;
        if (last_input_out !== 1'b0) begin
            miscompares++; $display("FAIL reset_last got %b want 0", last_input_out);
        end
        vectors++;
        for (int j = 0; j < 4; j++) begin
            if (word_out[j] !== 64'd0) begin
                miscompares++; $display("FAIL reset_word%0d got %h want 0", j, word_out[j]);
            end
            vectors++;
        end
    endtask

    task automatic test_directed;
        logic [3:0]  tv [6] = '{4'b0000, 4'b0100, 4'b1010, 4'b1111, 4'b1101, 4'b0000};
        logic [63:0] td [6][4] = '{
            '{64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA},
            '{64'hDEAD, 64'hBEEF, 64'h0000_0005_0000_0002, 64'hCAFE},
            '{64'h99, 64'h11, 64'h77, 64'h33},
            '{64'h10, 64'h20, 64'h30, 64'h40},
            '{64'h10, 64'h20, 64'h30, 64'h40},
            '{64'h5, 64'h6, 64'h7, 64'h8}};
        for (int c = 0; c < 6; c++) begin
            drive(1'b0, 1'b0, tv[c], td[c][0], td[c][1], td[c][2], td[c][3]);
            if (word_out_valid !== exp_valid) begin
                miscompares++;
                $display("FAIL directed%0d_valid got %b want %b", c, word_out_valid, exp_valid);
            end
            vectors++;
            for (int j = 0; j < 4; j++) begin
                if (word_out[j] !== exp_word[j]) begin
                    miscompares++;
                    $display("FAIL directed%0d_word%0d got %h want %h", c, j, word_out[j], exp_word[j]);
                end
                vectors++;
            end
        end
    endtask

    // All 16 patterns, random data, X on every invalid lane.
    task automatic test_all_patterns;
        logic [63:0] d [4];
        for (int p = 0; p < 16; p++) begin
            for (int k = 0; k < 4; k++)
                d[k] = p[k] ? {$urandom, $urandom} : 64'bx;
            drive(1'b0, 1'b0, 4'(p), d[0], d[1], d[2], d[3]);
            if (word_out_valid !== exp_valid || last_input_out !== exp_last) begin
                miscompares++;
                $display("FAIL pattern%0d_ctrl got %b/%b want %b/%b", p,
                         word_out_valid, last_input_out, exp_valid, exp_last);
            end
            vectors++;
            for (int j = 0; j < 4; j++) begin
                if (word_out[j] !== exp_word[j]) begin
                    miscompares++;
                    $display("FAIL pattern%0d_word%0d got %h want %h", p, j, word_out[j], exp_word[j]);
                end
                vectors++;
            end
        end
    endtask

    task automatic test_last;
        drive(1'b0, 1'b1, 4'b0001, 64'h7, 64'hx, 64'hx, 64'hx);
        if (last_input_out !== 1'b1 || word_out_valid !== 4'b1000 || word_out[0] !== 64'h7) begin
            miscompares++;
            $display("FAIL last_cycle got %b/%b/%h want 1/1000/7",
                     last_input_out, word_out_valid, word_out[0]);
        end
        vectors++;
        drive(1'b0, 1'b0, 4'b0000, 64'h1, 64'h2, 64'h3, 64'h4);
        if (last_input_out !== 1'b0 || word_out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL last_drop got %b/%b want 0/0000", last_input_out, word_out_valid);
        end
        vectors++;
    endtask

    task automatic test_reset_midstream;
        drive(1'b0, 1'b0, 4'b1111, 64'h10, 64'h20, 64'h30, 64'h40);
        drive(1'b1, 1'b1, 4'b0001, 64'h7, 64'h0, 64'h0, 64'h0);
        if (last_input_out !== 1'b0 || word_out_valid !== 4'b0000) begin
            miscompares++;
            $display("FAIL midrst_ctrl got %b/%b want 0/0000", last_input_out, word_out_valid);
        end
        vectors++;
        for (int j = 0; j < 4; j++) begin
            if (word_out[j] !== 64'd0) begin
                miscompares++; $display("FAIL midrst_word%0d got %h want 0", j, word_out[j]);
            end
            vectors++;
        end
    endtask

    task automatic test_back_to_back_random;
        for (int c = 0; c < 200; c++) begin
            drive(1'b0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                  {$urandom, $urandom}, {$urandom, $urandom},
                  {$urandom, $urandom}, {$urandom, $urandom});
            if (word_out_valid !== exp_valid || last_input_out !== exp_last) begin
                miscompares++;
                $display("FAIL random%0d_ctrl got %b/%b want %b/%b", c,
                         word_out_valid, last_input_out, exp_valid, exp_last);
            end
            vectors++;
            for (int j = 0; j < 4; j++) begin
                if (word_out[j] !== exp_word[j]) begin
                    miscompares++;
                    $display("FAIL random%0d_word%0d got %h want %h", c, j, word_out[j], exp_word[j]);
                end
                vectors++;
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        last_input_in = 1'b0;
        word_in_valid = 4'b0000;
        for (int k = 0; k < 4; k++) word_in[k] = 64'd0;
        @(posedge clk);
        #1;
        test_reset();
        test_directed();
        test_all_patterns();
        test_last();
        test_reset_midstream();
        test_back_to_back_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
